// File: rtl/bp_replace.sv
// bp_replace: bad-pixel replacement stage with a one-line buffer.
// Each flagged pixel is replaced with a value built from its already-corrected
// left (L) and upper (U) neighbours. Per-frame bad-pixel totals are reported
// when the frame ends.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_data/i_hs/i_vs    corrected pixel stream (i_hs = pixel valid, i_vs = frame)
//   i_bp_type           current pixel is bad (qualified by i_hs)
//   i_bypass            disable replacement, sampled at i_vs rising edge
//   o_data/o_hs/o_vs    output stream, fixed 2-cycle latency
//   o_bp_cnt/_vld       bad-pixel count of the last completed frame + update pulse
module bp_replace #(
    parameter int unsigned IMAGE_WIDE_LENGTH = 256,
    parameter int unsigned IMAGE_HIGH_LENGTH = 192,
    parameter int unsigned DW                = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [DW-1:0] i_data,
    input  logic          i_hs,
    input  logic          i_vs,
    input  logic          i_bp_type,
    input  logic          i_bypass,
    output logic [DW-1:0] o_data,
    output logic          o_hs,
    output logic          o_vs,
    output logic [15:0]   o_bp_cnt,
    output logic          o_bp_cnt_vld
);

    localparam int unsigned CW = $clog2(IMAGE_WIDE_LENGTH);
    localparam int unsigned RW = $clog2(IMAGE_HIGH_LENGTH);
    localparam int unsigned BW = 16;
    localparam logic [CW-1:0] COL_MAX = CW'(IMAGE_WIDE_LENGTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMAGE_HIGH_LENGTH - 1);
    localparam logic [BW-1:0] CNT_MAX = {BW{1'b1}};

    // Frame/line tracking
    logic          vs_prev_q, vs_prev_d;
    logic          hs_prev_q, hs_prev_d;
    logic          frame_active_q, frame_active_d;
    logic          bypass_q, bypass_d;
    logic [CW-1:0] col_q, col_d;
    logic          col_ovf_q, col_ovf_d;
    logic [RW-1:0] row_q, row_d;
    logic [BW-1:0] cnt_q, cnt_d;

    // Stage 1: registered input alongside the line-buffer read
    logic [DW-1:0] s1_data_q, s1_data_d;
    logic          s1_hs_q, s1_hs_d;
    logic          s1_vs_q, s1_vs_d;
    logic          s1_bad_q, s1_bad_d;
    logic          s1_row_nz_q, s1_row_nz_d;
    logic          s1_col_nz_q, s1_col_nz_d;
    logic          s1_wr_q, s1_wr_d;
    logic [CW-1:0] s1_col_q, s1_col_d;

    // Stage 2: output registers, left-neighbour register, line-buffer write port
    logic [DW-1:0] l_q, l_d;
    logic [DW-1:0] o_data_q, o_data_d;
    logic          o_hs_q, o_hs_d;
    logic          o_vs_q, o_vs_d;
    logic          wr_en_q, wr_en_d;
    logic [CW-1:0] wr_col_q, wr_col_d;
    logic [BW-1:0] o_bp_cnt_q, o_bp_cnt_d;
    logic          o_bp_cnt_vld_q, o_bp_cnt_vld_d;

    logic [DW-1:0] lb_rd_q;
    logic [DW-1:0] line_mem [IMAGE_WIDE_LENGTH];

    logic          vs_rise_c, vs_fall_c, hs_fall_c, bp_hit_c;
    logic [BW-1:0] cnt_inc_c;
    logic [DW:0]   sum_c;
    logic [DW-1:0] repl_c;

    assign vs_rise_c = i_vs & ~vs_prev_q;
    assign vs_fall_c = ~i_vs & vs_prev_q;
    assign hs_fall_c = ~i_hs & hs_prev_q;
    assign bp_hit_c  = i_hs & i_bp_type & frame_active_q;
    assign cnt_inc_c = (bp_hit_c && (cnt_q != CNT_MAX)) ? cnt_q + BW'(1) : cnt_q;

    // Average of L and U in DW+1 bits, truncated
    assign sum_c = {1'b0, l_q} + {1'b0, lb_rd_q};

    // Replacement selection for the pixel in stage 1
    always_comb begin
        repl_c = s1_data_q;
        if (s1_bad_q) begin
            case ({s1_row_nz_q, s1_col_nz_q})
                2'b11:   repl_c = sum_c[DW:1];
                2'b01:   repl_c = l_q;
                2'b10:   repl_c = lb_rd_q;
                default: repl_c = s1_data_q;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        vs_prev_d      = i_vs;
        hs_prev_d      = i_hs;
        frame_active_d = frame_active_q;
        bypass_d       = bypass_q;
        col_d          = col_q;
        col_ovf_d      = col_ovf_q;
        row_d          = row_q;
        cnt_d          = cnt_inc_c;
        o_bp_cnt_d     = o_bp_cnt_q;
        o_bp_cnt_vld_d = 1'b0;

        // Column counter saturates; pixels after the last column are flagged overflow
        if (i_hs) begin
            if (col_q == COL_MAX) begin
                col_ovf_d = 1'b1;
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (hs_fall_c) begin
            col_d     = '0;
            col_ovf_d = 1'b0;
        end

        if (vs_rise_c) begin
            row_d = '0;
        end else if (hs_fall_c && (row_q != ROW_MAX)) begin
            row_d = row_q + RW'(1);
        end

        if (vs_rise_c) begin
            frame_active_d = 1'b1;
            bypass_d       = i_bypass;
        end else if (vs_fall_c) begin
            frame_active_d = 1'b0;
        end

        // Frame end: publish the count including a bad pixel in this same cycle
        if (vs_fall_c) begin
            cnt_d = '0;
            if (frame_active_q) begin
                o_bp_cnt_d     = cnt_inc_c;
                o_bp_cnt_vld_d = 1'b1;
            end
        end

        s1_data_d   = i_data;
        s1_hs_d     = i_hs;
        s1_vs_d     = i_vs;
        s1_bad_d    = bp_hit_c & ~bypass_q & ~col_ovf_q;
        s1_row_nz_d = (row_q != '0);
        s1_col_nz_d = (col_q != '0);
        s1_wr_d     = i_hs & ~col_ovf_q;
        s1_col_d    = col_q;

        o_data_d = repl_c;
        o_hs_d   = s1_hs_q;
        o_vs_d   = s1_vs_q;
        // L only follows valid pixels so blank cycles do not disturb it
        l_d      = s1_hs_q ? repl_c : l_q;
        wr_en_d  = s1_hs_q & s1_wr_q;
        wr_col_d = s1_col_q;
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // vs_prev resets high so a reset in mid-frame cannot fake a rising edge
            vs_prev_q      <= 1'b1;
            hs_prev_q      <= 1'b0;
            frame_active_q <= 1'b0;
            bypass_q       <= 1'b0;
            col_q          <= '0;
            col_ovf_q      <= 1'b0;
            row_q          <= '0;
            cnt_q          <= '0;
            s1_data_q      <= '0;
            s1_hs_q        <= 1'b0;
            s1_vs_q        <= 1'b0;
            s1_bad_q       <= 1'b0;
            s1_row_nz_q    <= 1'b0;
            s1_col_nz_q    <= 1'b0;
            s1_wr_q        <= 1'b0;
            s1_col_q       <= '0;
            l_q            <= '0;
            o_data_q       <= '0;
            o_hs_q         <= 1'b0;
            o_vs_q         <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_col_q       <= '0;
            o_bp_cnt_q     <= '0;
            o_bp_cnt_vld_q <= 1'b0;
        end else begin
            vs_prev_q      <= vs_prev_d;
            hs_prev_q      <= hs_prev_d;
            frame_active_q <= frame_active_d;
            bypass_q       <= bypass_d;
            col_q          <= col_d;
            col_ovf_q      <= col_ovf_d;
            row_q          <= row_d;
            cnt_q          <= cnt_d;
            s1_data_q      <= s1_data_d;
            s1_hs_q        <= s1_hs_d;
            s1_vs_q        <= s1_vs_d;
            s1_bad_q       <= s1_bad_d;
            s1_row_nz_q    <= s1_row_nz_d;
            s1_col_nz_q    <= s1_col_nz_d;
            s1_wr_q        <= s1_wr_d;
            s1_col_q       <= s1_col_d;
            l_q            <= l_d;
            o_data_q       <= o_data_d;
            o_hs_q         <= o_hs_d;
            o_vs_q         <= o_vs_d;
            wr_en_q        <= wr_en_d;
            wr_col_q       <= wr_col_d;
            o_bp_cnt_q     <= o_bp_cnt_d;
            o_bp_cnt_vld_q <= o_bp_cnt_vld_d;
        end
    end

    // Line buffer: read at the stage-0 column, write stage-2 output at its column
    always_ff @(posedge i_clk) begin
        lb_rd_q <= line_mem[col_q];
        if (wr_en_q) begin
            line_mem[wr_col_q] <= o_data_q;
        end
    end

    assign o_data       = o_data_q;
    assign o_hs         = o_hs_q;
    assign o_vs         = o_vs_q;
    assign o_bp_cnt     = o_bp_cnt_q;
    assign o_bp_cnt_vld = o_bp_cnt_vld_q;

endmodule
